// File: rtl/nibble_serial_alu_pkg.sv
// Shared definitions for the nibble-serial ALU: op encodings and FSM state type.
package nibble_serial_alu_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_serial_alu_if.sv
// Request/result handshake bundle between a requester (master) and the ALU (slave).
interface nibble_serial_alu_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             overflow;
   logic             zero;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, cout, overflow, zero
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, cout, overflow, zero
   );
endinterface

// File: rtl/nibble_serial_alu_slice.sv
// One 4-bit ALU slice (AND/OR/ADD with optional b inversion); purely combinational.
// Overflow/set are meaningful only when this slice holds the operand MSB.
module nibble_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [2:0] op,
   input  logic       cin,
   output logic [3:0] result,
   output logic       cout,
   output logic       set,
   output logic       overflow
);
   logic [3:0] w_b;
   logic [4:0] w_sum;
   logic       w_cin_msb;

   always_comb begin
      w_b       = b ^ {4{op[2]}};
      w_sum     = {1'b0, a} + {1'b0, w_b} + {4'b0000, cin};
      w_cin_msb = a[3] ^ w_b[3] ^ w_sum[3];
      cout      = w_sum[4];
      overflow  = w_cin_msb ^ w_sum[4];
      set       = w_sum[3] ^ overflow;
      case (op[1:0])
         2'b00:   result = a & w_b;
         2'b01:   result = a | w_b;
         default: result = w_sum[3:0];
      endcase
   end
endmodule

// File: rtl/nibble_serial_alu.sv
// Serial ALU: one nibble per cycle through a shared slice, result NIB+1 cycles after accept.
// Holds result with out_valid until out_ready; in_ready low (requests dropped) while busy.
module nibble_serial_alu
   import nibble_serial_alu_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int NIB   = WIDTH / 4
) (
   input  logic              clk,
   input  logic              rst_n,
   nibble_serial_alu_if.slave s
);
   localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_op;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_set;
   logic             r_ovf;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_overflow;
   logic             r_zero;
   logic             r_in_ready;
   logic             r_out_valid;

   logic [3:0] w_nib_a;
   logic [3:0] w_nib_b;
   logic [3:0] w_slice_res;
   logic       w_slice_cout;
   logic       w_slice_set;
   logic       w_slice_ovf;

   assign w_nib_a = r_a[int'(r_cnt)*4 +: 4];
   assign w_nib_b = r_b[int'(r_cnt)*4 +: 4];

   nibble_slice u_slice (
      .a        (w_nib_a),
      .b        (w_nib_b),
      .op       (r_op),
      .cin      (r_carry),
      .result   (w_slice_res),
      .cout     (w_slice_cout),
      .set      (w_slice_set),
      .overflow (w_slice_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= OP_AND;
         r_cnt       <= '0;
         r_carry     <= 1'b0;
         r_set       <= 1'b0;
         r_ovf       <= 1'b0;
         r_result    <= '0;
         r_cout      <= 1'b0;
         r_overflow  <= 1'b0;
         r_zero      <= 1'b1;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (s.in_valid) begin
                  r_a        <= s.a;
                  r_b        <= s.b;
                  r_op       <= s.op;
                  r_cnt      <= '0;
                  r_carry    <= s.op[2];
                  r_in_ready <= 1'b0;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               r_result[int'(r_cnt)*4 +: 4] <= w_slice_res;
               r_carry <= w_slice_cout;
               r_set   <= w_slice_set;
               r_ovf   <= w_slice_ovf;
               if (r_cnt == CW'(NIB - 1)) begin
                  r_cnt   <= '0;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               // First DONE cycle settles flags (and the SLT rewrite) before out_valid rises.
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
                  case (r_op[1:0])
                     2'b11: begin
                        r_result   <= {{(WIDTH-1){1'b0}}, r_set};
                        r_cout     <= 1'b0;
                        r_overflow <= 1'b0;
                        r_zero     <= ~r_set;
                     end
                     2'b10: begin
                        r_cout     <= r_carry;
                        r_overflow <= r_ovf;
                        r_zero     <= (r_result == '0);
                     end
                     default: begin
                        r_cout     <= 1'b0;
                        r_overflow <= 1'b0;
                        r_zero     <= (r_result == '0);
                     end
                  endcase
               end else if (s.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign s.in_ready  = r_in_ready;
   assign s.out_valid = r_out_valid;
   assign s.result    = r_result;
   assign s.cout      = r_cout;
   assign s.overflow  = r_overflow;
   assign s.zero      = r_zero;
endmodule

// File: tb/tb_nibble_serial_alu.sv
// Directed bench for nibble_serial_alu with a queue scoreboard fed by a reference ALU model.
module tb_nibble_serial_alu;
   import nibble_serial_alu_pkg::*;

   typedef struct packed {
      logic [31:0] res;
      logic        cout;
      logic        ovf;
      logic        zero;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;
   exp_t sb[$];

   nibble_serial_alu_if #(.WIDTH(32)) bus ();

   nibble_serial_alu #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      logic [31:0] bb;
      logic [32:0] sum;
      logic        v;
      logic        st;
      exp_t        e;
      bb  = op[2] ? ~b : b;
      sum = {1'b0, a} + {1'b0, bb} + {32'd0, op[2]};
      v   = (a[31] == bb[31]) && (sum[31] != a[31]);
      st  = sum[31] ^ v;
      e.cout = 1'b0;
      e.ovf  = 1'b0;
      case (op[1:0])
         2'b00:   e.res = a & bb;
         2'b01:   e.res = a | bb;
         2'b10: begin
            e.res  = sum[31:0];
            e.cout = sum[32];
            e.ovf  = v;
         end
         default: e.res = {31'd0, st};
      endcase
      e.zero = (e.res == 32'd0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic pop_check(input string tag, output exp_t e);
      chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) e = sb.pop_front();
      else e = '0;
      chk({tag, "_result"},   64'(bus.result),   64'(e.res));
      chk({tag, "_cout"},     64'(bus.cout),     64'(e.cout));
      chk({tag, "_overflow"}, 64'(bus.overflow), 64'(e.ovf));
      chk({tag, "_zero"},     64'(bus.zero),     64'(e.zero));
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!bus.in_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (n >= 30) chk({tag, "_ready_timeout"}, 64'd1, 64'd0);
   endtask

   task automatic do_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [2:0] iop, input int hold, input bit pulse);
      int   lat;
      exp_t e;
      wait_ready(tag);
      bus.in_valid = 1'b1;
      bus.a        = ia;
      bus.b        = ib;
      bus.op       = iop;
      sb.push_back(model(ia, ib, iop));
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
         if (pulse && lat == 2) begin
            bus.in_valid = 1'b1;
            bus.a        = 32'hDEAD_BEEF;
            bus.b        = 32'h1234_5678;
            bus.op       = OP_OR;
         end else if (pulse && lat == 3) begin
            bus.in_valid = 1'b0;
         end
      end
      chk({tag, "_latency"}, 64'(lat), 64'd9);
      pop_check(tag, e);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"},  64'(bus.out_valid), 64'd1);
         chk({tag, "_hold_ready"},  64'(bus.in_ready),  64'd0);
         chk({tag, "_hold_result"}, 64'(bus.result),    64'(e.res));
         chk({tag, "_hold_flags"},  64'({bus.cout, bus.overflow, bus.zero}),
             64'({e.cout, e.ovf, e.zero}));
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
      chk({tag, "_ready_back"}, 64'(bus.in_ready),  64'd1);
   endtask

   initial begin
      int   seen;
      int   c;
      int   nres;
      int   tres[2];
      bit   acc;
      exp_t e;

      n_assert      = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.op        = OP_AND;
      bus.out_ready = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_result",    64'(bus.result),    64'd0);
      chk("rst_cout",      64'(bus.cout),      64'd0);
      chk("rst_overflow",  64'(bus.overflow),  64'd0);
      chk("rst_zero",      64'(bus.zero),      64'd1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
      chk("rst_valid_rel", 64'(bus.out_valid), 64'd0);

      do_op("add_basic", 32'h0000_000F, 32'h0000_0001, OP_ADD, 0, 1'b0);
      do_op("sub_ovf",   32'h8000_0000, 32'h0000_0001, OP_SUB, 0, 1'b0);
      do_op("slt_true",  32'hFFFF_FFFF, 32'h0000_0001, OP_SLT, 0, 1'b0);
      do_op("slt_false", 32'h0000_0001, 32'hFFFF_FFFF, OP_SLT, 0, 1'b0);
      do_op("and_hold",  32'hF0F0_F0F0, 32'hFF00_FF00, OP_AND, 5, 1'b0);
      do_op("or_basic",  32'h1234_5678, 32'h0F0F_0000, OP_OR,  0, 1'b0);
      do_op("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 0, 1'b0);
      do_op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 0, 1'b0);
      do_op("sub_zero",  32'h1357_9BDF, 32'h1357_9BDF, OP_SUB, 0, 1'b0);
      do_op("op100",     32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 0, 1'b0);
      do_op("op101",     32'h0000_0000, 32'h0F0F_0F0F, 3'b101, 0, 1'b0);
      do_op("op011",     32'h7000_0000, 32'h7000_0000, 3'b011, 0, 1'b0);

      do_op("pulse_ign", 32'h0000_00A5, 32'h0000_005A, OP_ADD, 0, 1'b1);
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      chk("pulse_no_extra", 64'(seen), 64'd0);

      wait_ready("abort");
      bus.in_valid = 1'b1;
      bus.a        = 32'h1111_1111;
      bus.b        = 32'h2222_2222;
      bus.op       = OP_ADD;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_valid",    64'(bus.out_valid), 64'd0);
      chk("abort_result",   64'(bus.result),    64'd0);
      chk("abort_flags",    64'({bus.cout, bus.overflow, bus.zero}), 64'b001);
      rst_n = 1'b1;
      seen  = 0;
      repeat (15) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      chk("abort_no_valid", 64'(seen), 64'd0);
      chk("abort_ready",    64'(bus.in_ready), 64'd1);
      do_op("after_abort", 32'h0000_1000, 32'h0000_0FFF, OP_SUB, 0, 1'b0);

      bus.out_ready = 1'b1;
      wait_ready("b2b");
      bus.in_valid = 1'b1;
      bus.a        = 32'hAAAA_0000;
      bus.b        = 32'h0000_5555;
      bus.op       = OP_ADD;
      sb.push_back(model(32'hAAAA_0000, 32'h0000_5555, OP_ADD));
      @(posedge clk);
      @(negedge clk);
      bus.a  = 32'h0000_0003;
      bus.b  = 32'h0000_0005;
      bus.op = OP_SUB;
      sb.push_back(model(32'h0000_0003, 32'h0000_0005, OP_SUB));
      c       = 0;
      nres    = 0;
      tres[0] = -1;
      tres[1] = -1;
      while (nres < 2 && c < 60) begin
         if (bus.out_valid) begin
            tres[nres] = c;
            pop_check((nres == 0) ? "b2b_first" : "b2b_second", e);
            nres++;
         end
         acc = bus.in_ready && bus.in_valid;
         @(posedge clk);
         @(negedge clk);
         c++;
         if (acc) bus.in_valid = 1'b0;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk("b2b_count",  64'(nres),    64'd2);
      chk("b2b_first_t", 64'(tres[0]), 64'd9);
      chk("b2b_period", 64'(tres[1] - tres[0]), 64'd11);

      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
